// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
// mem_ctrl: byte-serial memory controller between the CPU pipeline and a
// single-port 8-bit RAM bus.
//
// Serves 32-bit instruction fetches (if_request/if_addr -> if_inst/if_enable)
// and 1/2/4-byte loads and stores (mem_* ports). A load/store request wins over
// a simultaneous fetch. Each access is split into byte cycles on ram_a/ram_dout/
// ram_wr, with read bytes arriving on ram_din one cycle after their address.
// A taken jump (jump_or_not) aborts an in-flight fetch. rdy low freezes the
// controller and suppresses ram_wr.
//
// Ports: clk, rst (sync, active-high), rdy; fetch side if_request, if_addr,
// if_inst, if_enable, jump_or_not; load/store side mem_request, mem_write,
// mem_addr, mem_len, mem_wdata, mem_rdata, mem_enable; RAM side ram_din,
// ram_dout, ram_a, ram_wr; io_buffer_full.
//
// Build option: define MEMCTRL_IO_STALL_EN to hold off stores to the IO window
// (mem_addr[17:16] == 2'b11) while io_buffer_full is high. Without it,
// io_buffer_full has no effect.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_request,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_enable,
  input  logic        jump_or_not,
  input  logic        mem_request,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_enable,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [2:0]  len_r, len_nxt_s;
  logic [31:0] base_r, base_nxt_s;
  logic [31:0] wdata_r, wdata_nxt_s;
  logic [31:0] data_r, data_nxt_s, data_upd_s;
  logic        is_if_r, is_if_nxt_s;
  logic [31:0] if_inst_r, if_inst_nxt_s;
  logic        if_enable_r, if_enable_nxt_s;
  logic [31:0] mem_rdata_r, mem_rdata_nxt_s;
  logic        mem_enable_r, mem_enable_nxt_s;
  logic [31:0] ram_a_r, ram_a_nxt_s;
  logic [7:0]  ram_dout_r, ram_dout_nxt_s;
  logic        ram_wr_r, ram_wr_nxt_s;
  logic        io_block_s;

  // Byte count of a load/store; the reserved encoding 11 behaves as a word.
  function automatic logic [2:0] len_of(input logic [1:0] l);
    case (l)
      2'b00:   len_of = 3'd1;
      2'b01:   len_of = 3'd2;
      default: len_of = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    get_byte = w[7:0];
      3'd1:    get_byte = w[15:8];
      3'd2:    get_byte = w[23:16];
      3'd3:    get_byte = w[31:24];
      default: get_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [2:0] idx,
                                           input logic [7:0] b);
    put_byte = w;
    case (idx)
      3'd0:    put_byte[7:0]   = b;
      3'd1:    put_byte[15:8]  = b;
      3'd2:    put_byte[23:16] = b;
      3'd3:    put_byte[31:24] = b;
      default: put_byte = w;
    endcase
  endfunction

`ifdef MEMCTRL_IO_STALL_EN
  assign io_block_s = mem_request & mem_write & (mem_addr[17:16] == 2'b11) & io_buffer_full;
`else
  assign io_block_s = io_buffer_full & 1'b0;
`endif

  assign cnt_inc_s  = cnt_r + 3'd1;
  // ram_din in the cycle with cnt = k belongs to byte k-1.
  assign data_upd_s = put_byte(data_r, cnt_r - 3'd1, ram_din);

  // Next-state and next-output logic; outputs are registered so each value
  // computed here is what the bus sees in the following cycle.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    len_nxt_s        = len_r;
    base_nxt_s       = base_r;
    wdata_nxt_s      = wdata_r;
    data_nxt_s       = data_r;
    is_if_nxt_s      = is_if_r;
    if_inst_nxt_s    = if_inst_r;
    if_enable_nxt_s  = 1'b0;
    mem_rdata_nxt_s  = mem_rdata_r;
    mem_enable_nxt_s = 1'b0;
    ram_a_nxt_s      = 32'h0;
    ram_dout_nxt_s   = 8'h00;
    ram_wr_nxt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_request && !io_block_s) begin
          base_nxt_s  = mem_addr;
          len_nxt_s   = len_of(mem_len);
          wdata_nxt_s = mem_wdata;
          data_nxt_s  = 32'h0;
          cnt_nxt_s   = 3'd0;
          is_if_nxt_s = 1'b0;
          ram_a_nxt_s = mem_addr;
          if (mem_write) begin
            state_nxt_s    = MEM_WR;
            ram_wr_nxt_s   = 1'b1;
            ram_dout_nxt_s = mem_wdata[7:0];
          end else begin
            state_nxt_s = MEM_RD;
          end
        end else if (!mem_request && if_request && !jump_or_not) begin
          // A pending (even IO-stalled) load/store keeps fetches waiting.
          state_nxt_s = IF_RD;
          base_nxt_s  = if_addr;
          len_nxt_s   = 3'd4;
          data_nxt_s  = 32'h0;
          cnt_nxt_s   = 3'd0;
          is_if_nxt_s = 1'b1;
          ram_a_nxt_s = if_addr;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      IF_RD, MEM_RD: begin
        if ((state_r == IF_RD) && jump_or_not) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 3'd0;
          data_nxt_s  = 32'h0;
        end else if (cnt_r == len_r) begin
          state_nxt_s = DONE;
          cnt_nxt_s   = 3'd0;
          data_nxt_s  = data_upd_s;
          if (is_if_r) begin
            if_inst_nxt_s   = data_upd_s;
            if_enable_nxt_s = 1'b1;
          end else begin
            mem_rdata_nxt_s  = data_upd_s;
            mem_enable_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_inc_s;
          if (cnt_r != 3'd0) begin
            data_nxt_s = data_upd_s;
          end else begin
            data_nxt_s = data_r;
          end
          if (cnt_inc_s < len_r) begin
            ram_a_nxt_s = base_r + {29'd0, cnt_inc_s};
          end else begin
            ram_a_nxt_s = 32'h0;
          end
        end
      end
      MEM_WR: begin
        if (cnt_inc_s == len_r) begin
          state_nxt_s      = DONE;
          cnt_nxt_s        = 3'd0;
          mem_enable_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s      = cnt_inc_s;
          ram_a_nxt_s    = base_r + {29'd0, cnt_inc_s};
          ram_dout_nxt_s = get_byte(wdata_r, cnt_inc_s);
          ram_wr_nxt_s   = 1'b1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // State and output registers; rdy low freezes everything, including a DONE strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      len_r        <= 3'd0;
      base_r       <= 32'h0;
      wdata_r      <= 32'h0;
      data_r       <= 32'h0;
      is_if_r      <= 1'b0;
      if_inst_r    <= 32'h0;
      if_enable_r  <= 1'b0;
      mem_rdata_r  <= 32'h0;
      mem_enable_r <= 1'b0;
      ram_a_r      <= 32'h0;
      ram_dout_r   <= 8'h00;
      ram_wr_r     <= 1'b0;
    end else if (rdy) begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      len_r        <= len_nxt_s;
      base_r       <= base_nxt_s;
      wdata_r      <= wdata_nxt_s;
      data_r       <= data_nxt_s;
      is_if_r      <= is_if_nxt_s;
      if_inst_r    <= if_inst_nxt_s;
      if_enable_r  <= if_enable_nxt_s;
      mem_rdata_r  <= mem_rdata_nxt_s;
      mem_enable_r <= mem_enable_nxt_s;
      ram_a_r      <= ram_a_nxt_s;
      ram_dout_r   <= ram_dout_nxt_s;
      ram_wr_r     <= ram_wr_nxt_s;
    end
  end

  assign if_inst    = if_inst_r;
  assign if_enable  = if_enable_r;
  assign mem_rdata  = mem_rdata_r;
  assign mem_enable = mem_enable_r;
  assign ram_a      = ram_a_r;
  assign ram_dout   = ram_dout_r;
  // A frozen write cycle must not hit the RAM.
  assign ram_wr     = ram_wr_r & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
// Testbench for mem_ctrl: byte-wide RAM model with one-cycle read latency,
// directed fetch/load/store sequences, and scoreboard queues of expected
// fetch words, load data and RAM write bytes, checked as the DUT produces them.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_request;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_enable;
  logic        jump_or_not;
  logic        mem_request;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_enable;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] if_q[$];
  logic [32:0] mem_q[$];   // {is_load, expected rdata}
  logic [39:0] wr_q[$];    // {address, byte}

  logic [7:0] ram [0:262143];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_request(if_request), .if_addr(if_addr), .if_inst(if_inst), .if_enable(if_enable),
    .jump_or_not(jump_or_not),
    .mem_request(mem_request), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_enable(mem_enable),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registers the address each edge, returns its byte next cycle.
  always @(posedge clk) begin
    if (rst) begin
      ram_din <= 8'h00;
      ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h05; ram[18'h00102] = 8'h00; ram[18'h00103] = 8'h00;
      ram[18'h00040] = 8'h93; ram[18'h00041] = 8'h00; ram[18'h00042] = 8'h10; ram[18'h00043] = 8'h00;
      ram[18'h00044] = 8'h13; ram[18'h00045] = 8'h01; ram[18'h00046] = 8'h20; ram[18'h00047] = 8'h00;
      ram[18'h00300] = 8'h80;
    end else begin
      ram_din <= ram[ram_a[17:0]];
      if (ram_wr) ram[ram_a[17:0]] = ram_dout;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_strobe(input logic use_mem, input int maxc, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < maxc) begin
      @(negedge clk);
      n++;
      seen = use_mem ? mem_enable : if_enable;
    end
    check_eq(use_mem ? "mem_done_timeout" : "if_done_timeout", 64'(seen), 64'd1);
  endtask

  // Fetch scoreboard.
  always @(negedge clk) begin
    if (!rst && if_enable) begin
      if (if_q.size() == 0) check_eq("if_unexpected", 64'(if_q.size()), 64'd1);
      else check_eq("if_inst", 64'(if_inst), 64'(if_q.pop_front()));
    end
  end

  // Load/store completion scoreboard.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && mem_enable) begin
      if (mem_q.size() == 0) begin
        check_eq("mem_unexpected", 64'(mem_q.size()), 64'd1);
      end else begin
        e = mem_q.pop_front();
        if (e[32]) check_eq("mem_rdata", 64'(mem_rdata), 64'(e[31:0]));
      end
    end
  end

  // RAM write scoreboard.
  always @(negedge clk) begin
    if (!rst && ram_wr) begin
      if (wr_q.size() == 0) check_eq("wr_unexpected", 64'(wr_q.size()), 64'd1);
      else check_eq("ram_write", 64'({ram_a, ram_dout}), 64'(wr_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; rdy = 1'b1; if_request = 1'b0; if_addr = 32'h0; jump_or_not = 1'b0;
    mem_request = 1'b0; mem_write = 1'b0; mem_addr = 32'h0; mem_len = 2'b00;
    mem_wdata = 32'h0; io_buffer_full = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_if", 64'({if_inst, if_enable}), 64'd0);
    check_eq("rst_mem", 64'({mem_rdata, mem_enable}), 64'd0);
    check_eq("rst_ram", 64'({ram_a, ram_dout, ram_wr}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 4-byte fetch from 0x100.
    if_q.push_back(32'h00000513);
    if_addr = 32'h100; if_request = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) check_eq("fetch_ram_a", 64'(ram_a), 64'(32'h100 + k));
      check_eq("fetch_enable", 64'(if_enable), 64'(k == 5));
    end
    if_request = 1'b0;
    @(negedge clk);

    // 4-byte store of 0xDEADBEEF at 0x200.
    wr_q.push_back({32'h200, 8'hEF}); wr_q.push_back({32'h201, 8'hBE});
    wr_q.push_back({32'h202, 8'hAD}); wr_q.push_back({32'h203, 8'hDE});
    mem_q.push_back({1'b0, 32'h0});
    mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF; mem_len = 2'b10; mem_write = 1'b1;
    mem_request = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("store_wr", 64'(ram_wr), 64'(k < 4));
      check_eq("store_enable", 64'(mem_enable), 64'(k == 4));
    end
    mem_request = 1'b0;
    @(negedge clk);

    // Word load back from 0x200; strobe in C5.
    mem_q.push_back({1'b1, 32'hDEADBEEF});
    mem_write = 1'b0; mem_len = 2'b10; mem_addr = 32'h200; mem_request = 1'b1;
    wait_strobe(1'b1, 10, n);
    check_eq("load4_latency", 64'(n), 64'd6);
    mem_request = 1'b0;
    @(negedge clk);

    // Simultaneous fetch and 1-byte load: load first, fetch accepted at E4.
    mem_q.push_back({1'b1, 32'h00000080});
    if_q.push_back(32'h00000513);
    mem_addr = 32'h300; mem_len = 2'b00; mem_write = 1'b0; mem_request = 1'b1;
    if_addr = 32'h100; if_request = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) check_eq("arb_ram_a", 64'(ram_a), 64'h300);
      check_eq("arb_mem_enable", 64'(mem_enable), 64'(k == 2));
    end
    mem_request = 1'b0;
    @(negedge clk);
    check_eq("arb_gap_ram_a", 64'(ram_a), 64'h0);
    @(negedge clk);
    check_eq("arb_fetch_ram_a", 64'(ram_a), 64'h100);
    wait_strobe(1'b0, 8, n);
    check_eq("arb_fetch_latency", 64'(n), 64'd5);
    if_request = 1'b0;
    @(negedge clk);

    // Jump in C2 aborts a fetch; a new fetch at 0x40 then completes.
    if_addr = 32'h100; if_request = 1'b1;
    repeat (3) @(negedge clk);
    jump_or_not = 1'b1; if_request = 1'b0;
    @(negedge clk);
    check_eq("jump_ram_a", 64'(ram_a), 64'h0);
    jump_or_not = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("jump_no_enable", 64'(if_enable), 64'd0);
    end
    if_q.push_back(32'h00100093);
    if_addr = 32'h40; if_request = 1'b1;
    wait_strobe(1'b0, 10, n);
    check_eq("refetch_latency", 64'(n), 64'd6);
    if_request = 1'b0;
    @(negedge clk);

    // rdy low in IDLE: the pending fetch is not taken until rdy returns.
    if_q.push_back(32'h00200113);
    rdy = 1'b0; if_addr = 32'h44; if_request = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("rdy_frozen_ram_a", 64'(ram_a), 64'h0);
    end
    rdy = 1'b1;
    wait_strobe(1'b0, 10, n);
    check_eq("rdy_fetch_latency", 64'(n), 64'd6);
    if_request = 1'b0;
    @(negedge clk);

    // Store to the IO window while the UART buffer is full.
    wr_q.push_back({32'h30000, 8'h5A});
    mem_q.push_back({1'b0, 32'h0});
    mem_addr = 32'h30000; mem_wdata = 32'h0000005A; mem_len = 2'b00; mem_write = 1'b1;
    io_buffer_full = 1'b1; mem_request = 1'b1;
`ifdef MEMCTRL_IO_STALL_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("io_stall_wr", 64'(ram_wr), 64'd0);
    end
    io_buffer_full = 1'b0;
`endif
    @(negedge clk);
    check_eq("io_wr", 64'(ram_wr), 64'd1);
    wait_strobe(1'b1, 5, n);
    check_eq("io_store_latency", 64'(n), 64'd1);
    mem_request = 1'b0; io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("if_q_drained", 64'(if_q.size()), 64'd0);
    check_eq("mem_q_drained", 64'(mem_q.size()), 64'd0);
    check_eq("wr_q_drained", 64'(wr_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the pipeline and the single-port 8-bit RAM bus. It serves the instruction-fetch stage's `if_request`/`if_addr` with 32-bit `if_inst`/`if_enable`, and the MEM stage's 1/2/4-byte loads and stores. It arbitrates between the two requesters and converts each access into a sequence of byte cycles. A taken jump aborts an in-flight fetch.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-high
- `rdy` in 1: global ready; low freezes all state
- `if_request` in 1: fetch request, level, held until `if_enable`
- `if_addr` in 32: fetch byte address (word aligned)
- `if_inst` out 32: fetched instruction, valid while `if_enable`
- `if_enable` out 1: one-cycle fetch-done strobe
- `jump_or_not` in 1: taken branch/jump; cancels a fetch
- `mem_request` in 1: load/store request, level, held until `mem_enable`
- `mem_write` in 1: 1 = store, 0 = load
- `mem_addr` in 32: load/store byte address
- `mem_len` in 2: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes; 11 is treated as 4
- `mem_wdata` in 32: store data, little-endian, low bytes used
- `mem_rdata` out 32: load data, zero-extended, valid while `mem_enable`
- `mem_enable` out 1: one-cycle load/store-done strobe
- `ram_din` in 8: RAM read byte; returns data for the address registered at the previous edge
- `ram_dout` out 8: RAM write byte
- `ram_a` out 32: RAM byte address
- `ram_wr` out 1: 1 = write this cycle
- `io_buffer_full` in 1: UART buffer full; see Configuration

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- Byte counter `cnt` is 3 bits. Base address and length are latched on accept.
- Byte address for byte k is base + k, 32-bit wraparound.
- **IDLE accept:**
  - `mem_request` has priority over `if_request`.
  - A fetch is not accepted in a cycle where `jump_or_not` = 1.
  - Otherwise, accept goes to MEM_WR, MEM_RD or IF_RD with `cnt` = 0.
- **Read (len N: 4 for IF, from `mem_len` for MEM):**
  - In the cycle with `cnt` = k < N, drive `ram_a` = base + k.
  - At the edge ending the cycle with `cnt` = k ≥ 1, latch `ram_din` into byte k−1.
  - A final cycle with `cnt` = N captures the last byte, then the state goes to DONE.
- **Write:**
  - In the cycle with `cnt` = k < N, drive `ram_a` = base + k, `ram_dout` = `mem_wdata` byte k, and `ram_wr` = 1.
  - After `cnt` = N−1, the state goes to DONE.
- **DONE:**
  - Lasts one cycle; the matching `if_enable` or `mem_enable` is 1.
  - Data outputs hold the assembled word.
  - Requests are ignored; the next state is IDLE.
- **Jump during IF_RD:** when `jump_or_not` = 1, the next state is IDLE, there is no `if_enable`, and partial data is discarded. MEM_RD and MEM_WR are never aborted.
- **`rdy` = 0:** state, counter and data registers hold. `ram_wr` is forced to 0, and a held DONE keeps its strobe.
- **Outside active write cycles:** `ram_wr` = 0 and `ram_a` = 0 in IDLE and DONE.

## Timing
- **Reset values:** state IDLE, `cnt` = 0, and every output 0 (`if_inst`, `if_enable`, `mem_rdata`, `mem_enable`, `ram_a`, `ram_dout`, `ram_wr`).
- **Numbering:** request sampled at edge E0; cycle Ck follows edge Ek.
- **4-byte read:**
  - Addresses are driven in C0..C3.
  - Bytes 0..3 are latched at E2..E5.
  - The strobe is high in C5.
  - Earliest next accept is at E7.
- **N-byte read:** strobe in cycle C(N+1).
- **N-byte write:** `ram_wr` high C0..C(N−1); strobe in CN.
- **Back-to-back gap:** one idle cycle between DONE and the next access.
- **Simultaneous arrival:** when both requests arrive in the same IDLE cycle, the MEM access is served first and the fetch follows.

## Configuration
- **`MEMCTRL_IO_STALL_EN` defined:** a store with `mem_addr[17:16]` = 2'b11 is not accepted while `io_buffer_full` = 1. It waits in IDLE, and fetches are also held off meanwhile, because MEM has priority.
- **Not defined:** `io_buffer_full` is ignored and IO stores proceed immediately.

## Test plan
- **Reset:** `rst` = 1 for 2 cycles → all outputs 0, state IDLE.
- **4-byte fetch:** fetch `if_addr` = 0x100, RAM bytes 0x13, 0x05, 0x00, 0x00 → `ram_a` = 0x100..0x103 in C0..C3; `if_enable` = 1 only in C5 with `if_inst` = 0x00000513.
- **4-byte store:** `mem_addr` = 0x200, `mem_wdata` = 0xDEADBEEF, `mem_len` = 10 → `ram_wr` high C0..C3 with bytes EF, BE, AD, DE at 0x200..0x203; `mem_enable` = 1 in C4.
- **Arbitration:** `if_request` and a 1-byte load at 0x300 (byte 0x80) raised together → load first, `mem_rdata` = 0x00000080 in C2; fetch accepted at E4.
- **Jump abort:** `jump_or_not` = 1 in C2 of a fetch → IDLE next edge, no `if_enable`; a new fetch at 0x40 completes normally.
- **IO stall (macro on):** store to 0x30000 while `io_buffer_full` = 1 for 3 cycles → no `ram_wr` until `io_buffer_full` drops; with macro off, the write starts in C0.
